// File: rtl/cache_miss_handler.sv
// Blocking single-miss refill controller between the CPU load port, the cache arrays and memory.
// Define REFILL_TIMEOUT_EN to add the refill timeout counter and the oError pulse.
module cache_miss_handler #(
    parameter int unsigned INDEX_WIDTH = 4,
    parameter int unsigned TAG_WIDTH   = 26,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                   iCLK,
    input  logic                   iRSTn,
    input  logic                   iReq,
    input  logic [31:0]            iAddr,
    input  logic                   iHit,
    input  logic [31:0]            iCacheData,
    input  logic                   iFlush,
    output logic                   oStall,
    output logic [31:0]            oData,
    output logic                   oDataValid,
    output logic                   oMemReq,
    output logic [31:0]            oMemAddr,
    input  logic                   iMemAck,
    input  logic                   iMemValid,
    input  logic [31:0]            iMemData,
    output logic                   oFillEn,
    output logic [INDEX_WIDTH-1:0] oFillIndex,
    output logic [TAG_WIDTH-1:0]   oFillTag,
    output logic [31:0]            oFillData,
    output logic [15:0]            oMissCount
`ifdef REFILL_TIMEOUT_EN
    ,
    output logic                   oError
`endif
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StFill, StResp} state_e;

    state_e      state_q, state_d;
    logic [29:0] word_q, word_d;
    logic [31:0] fill_q, fill_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic [15:0] miss_q, miss_d;
    logic        drop_q, drop_d;
    logic        idle_hit, idle_miss;

    // Byte offset never reaches memory or the cache arrays.
    logic unused_addr_bits;
    assign unused_addr_bits = ^iAddr[1:0];

`ifdef REFILL_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 32'd0);
`endif

    // A flush in IDLE wins over a request: no hit response and no miss that cycle.
    assign idle_hit  = (state_q == StIdle) && iReq && iHit && !iFlush;
    assign idle_miss = (state_q == StIdle) && iReq && !iHit && !iFlush;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        fill_d  = fill_q;
        data_d  = data_q;
        valid_d = 1'b0;
        miss_d  = miss_q;
        drop_d  = drop_q;
        case (state_q)
            StIdle: begin
                if (idle_hit) begin
                    data_d  = iCacheData;
                    valid_d = 1'b1;
                end else if (idle_miss) begin
                    word_d  = iAddr[31:2];
                    miss_d  = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (iFlush) drop_d = 1'b1;
                if (iMemAck) begin
                    if (iMemValid) begin
                        fill_d  = iMemData;
                        state_d = StFill;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (iFlush) drop_d = 1'b1;
                if (iMemValid) begin
                    fill_d  = iMemData;
                    state_d = StFill;
                end
            end
            StFill: begin
                data_d  = fill_q;
                valid_d = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                drop_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
`ifdef REFILL_TIMEOUT_EN
        err_d = 1'b0;
        cnt_d = '0;
        if (state_q == StReq || state_q == StWait) begin
            // Timeout overrides any memory handshake arriving in the same cycle.
            if (cnt_q == CntW'(TIMEOUT - 1)) begin
                data_d  = '0;
                valid_d = 1'b1;
                err_d   = 1'b1;
                state_d = StResp;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q <= StIdle;
            word_q  <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            miss_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            miss_q  <= miss_d;
            drop_q  <= drop_d;
        end
    end

`ifdef REFILL_TIMEOUT_EN
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign oError = err_q;
`endif

    always_comb begin
        oStall     = iRSTn && ((state_q == StReq) || (state_q == StWait) ||
                               (state_q == StFill) || idle_miss);
        oMemReq    = (state_q == StReq);
        oMemAddr   = {word_q, 2'b00};
        oFillEn    = (state_q == StFill) && !drop_q;
        oFillIndex = word_q[INDEX_WIDTH-1:0];
        oFillTag   = word_q[29 -: TAG_WIDTH];
        oFillData  = fill_q;
        oData      = data_q;
        oDataValid = valid_q;
        oMissCount = miss_q;
    end

endmodule

// File: tb/tb_cache_miss_handler.sv
// Self-checking bench for cache_miss_handler: directed cases plus randomized load transactions
// checked against a transaction-level model of latencies, fills and responses.
module tb_cache_miss_handler;

    localparam int unsigned IW = 4;
    localparam int unsigned TW = 26;
    localparam int unsigned TO = 8;

    logic          iCLK = 1'b0;
    logic          iRSTn = 1'b1;
    logic          iReq = 1'b0;
    logic [31:0]   iAddr = '0;
    logic          iHit = 1'b0;
    logic [31:0]   iCacheData = '0;
    logic          iFlush = 1'b0;
    logic          iMemAck = 1'b0;
    logic          iMemValid = 1'b0;
    logic [31:0]   iMemData = '0;
    logic          oStall;
    logic [31:0]   oData;
    logic          oDataValid;
    logic          oMemReq;
    logic [31:0]   oMemAddr;
    logic          oFillEn;
    logic [IW-1:0] oFillIndex;
    logic [TW-1:0] oFillTag;
    logic [31:0]   oFillData;
    logic [15:0]   oMissCount;
`ifdef REFILL_TIMEOUT_EN
    logic          oError;
`endif

    int total = 0;
    int bad = 0;
    int model_misses = 0;

    always #5 iCLK = ~iCLK;

    cache_miss_handler #(
        .INDEX_WIDTH(IW),
        .TAG_WIDTH  (TW),
        .TIMEOUT    (TO)
    ) dut (
        .iCLK       (iCLK),
        .iRSTn      (iRSTn),
        .iReq       (iReq),
        .iAddr      (iAddr),
        .iHit       (iHit),
        .iCacheData (iCacheData),
        .iFlush     (iFlush),
        .oStall     (oStall),
        .oData      (oData),
        .oDataValid (oDataValid),
        .oMemReq    (oMemReq),
        .oMemAddr   (oMemAddr),
        .iMemAck    (iMemAck),
        .iMemValid  (iMemValid),
        .iMemData   (iMemData),
        .oFillEn    (oFillEn),
        .oFillIndex (oFillIndex),
        .oFillTag   (oFillTag),
        .oFillData  (oFillData),
`ifdef REFILL_TIMEOUT_EN
        .oMissCount (oMissCount),
        .oError     (oError)
`else
        .oMissCount (oMissCount)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle_inputs();
        iReq = 1'b0;
        iHit = 1'b0;
        iFlush = 1'b0;
        iMemAck = 1'b0;
        iMemValid = 1'b0;
    endtask

    function automatic logic [63:0] exp_index(input logic [31:0] a);
        return 64'((a >> 2) % (32'd1 << IW));
    endfunction

    function automatic logic [63:0] exp_tag(input logic [31:0] a);
        return 64'(a >> (32 - TW));
    endfunction

    task automatic do_hit(input logic [31:0] addr, input logic [31:0] data, input logic flush);
        iReq = 1'b1;
        iHit = 1'b1;
        iAddr = addr;
        iCacheData = data;
        iFlush = flush;
        #1;
        check("hit_stall", oStall, 0);
        next_cycle();
        idle_inputs();
        iCacheData = $urandom;
        #1;
        check("hit_valid", oDataValid, !flush);
        if (!flush) check("hit_data", oData, data);
        check("hit_miss_count", oMissCount, model_misses);
        next_cycle();
        check("hit_pulse_end", oDataValid, 0);
    endtask

    task automatic do_flush_req();
        iReq = 1'b1;
        iHit = 1'b0;
        iAddr = $urandom;
        iFlush = 1'b1;
        #1;
        check("flush_req_stall", oStall, 0);
        next_cycle();
        idle_inputs();
        #1;
        check("flush_req_memreq", oMemReq, 0);
        check("flush_req_miss_count", oMissCount, model_misses);
    endtask

    // Memory acks a cycles into REQ; data follows d cycles after the ack (d=0: same cycle).
    // Response is then due 3+a+d cycles after the request; a flush inside the memory window
    // (cycles 1..1+a+d) drops the fill but not the response.
    task automatic do_miss(input logic [31:0] addr, input int a, input int d,
                           input logic [31:0] mdata, input int flush_at);
        int          last, stall_n, memreq_n, fill_n, fill_cyc, resp_n, resp_cyc;
        logic [31:0] fdata, rdata;
        logic [IW-1:0] fidx;
        logic [TW-1:0] ftag;
        logic        dropped;
        last = 3 + a + d;
        dropped = (flush_at >= 1) && (flush_at <= 1 + a + d);
        stall_n = 0; memreq_n = 0; fill_n = 0; fill_cyc = -1; resp_n = 0; resp_cyc = -1;
        fdata = '0; rdata = '0; fidx = '0; ftag = '0;
        for (int c = 0; c <= last + 1; c++) begin
            iReq = (c == 0) || (c < last && $urandom_range(0, 1) == 1);
            iAddr = addr;
            iHit = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            iCacheData = $urandom;
            iMemAck = (c == 1 + a);
            iMemValid = (c == 1 + a + d) ||
                        (((c >= 1 && c <= a) || c == 2 + a + d) && $urandom_range(0, 1) == 1);
            iMemData = (c == 1 + a + d) ? mdata : $urandom;
            iFlush = (c == flush_at);
            #1;
            if (oStall) stall_n++;
            if (oMemReq) begin
                memreq_n++;
                check("miss_memaddr", oMemAddr, addr & ~32'h3);
            end
            if (oFillEn) begin
                fill_n++;
                fill_cyc = c;
                fdata = oFillData;
                fidx = oFillIndex;
                ftag = oFillTag;
            end
            if (oDataValid) begin
                resp_n++;
                resp_cyc = c;
                rdata = oData;
            end
            next_cycle();
        end
        idle_inputs();
        model_misses++;
        check("miss_stall_cycles", stall_n, last);
        check("miss_memreq_cycles", memreq_n, a + 1);
        check("miss_resp_count", resp_n, 1);
        check("miss_resp_cycle", resp_cyc, last);
        check("miss_resp_data", rdata, mdata);
        if (dropped) begin
            check("miss_fill_dropped", fill_n, 0);
        end else begin
            check("miss_fill_count", fill_n, 1);
            check("miss_fill_cycle", fill_cyc, last - 1);
            check("miss_fill_data", fdata, mdata);
            check("miss_fill_index", fidx, exp_index(addr));
            check("miss_fill_tag", ftag, exp_tag(addr));
        end
        check("miss_count", oMissCount, model_misses);
    endtask

    initial begin
        int fills, resps, stalls, a, d, fl, kind;
`ifdef REFILL_TIMEOUT_EN
        int err_n, err_cyc, resp_cyc;
        logic [31:0] rdata;
`endif
        idle_inputs();
        #2 iRSTn = 1'b0;
        #1;
        check("rst_stall", oStall, 0);
        check("rst_memreq", oMemReq, 0);
        check("rst_fillen", oFillEn, 0);
        check("rst_valid", oDataValid, 0);
        check("rst_data", oData, 0);
        check("rst_memaddr", oMemAddr, 0);
        check("rst_filldata", oFillData, 0);
        check("rst_fillindex", oFillIndex, 0);
        check("rst_filltag", oFillTag, 0);
        check("rst_misscount", oMissCount, 0);
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        iRSTn = 1'b1;
        next_cycle();

        do_hit(32'h0000_0040, 32'hDEAD_BEEF, 1'b0);
        do_miss(32'h1234_5678, 1, 2, 32'hCAFE_F00D, -1);
        do_miss(32'h8765_4320, 0, 0, 32'h0BAD_CAFE, -1);
        do_miss(32'h0000_1F04, 0, 3, 32'h1357_9BDF, 2);
        do_miss(32'h0000_1F04, 2, 1, 32'h2468_ACE0, -1);
        do_hit(32'h0000_0080, 32'h5555_AAAA, 1'b1);
        do_flush_req();

        // Reset while the refill is waiting on memory: everything abandoned.
        iReq = 1'b1;
        iHit = 1'b0;
        iAddr = 32'hABCD_0010;
        next_cycle();
        iReq = 1'b0;
        iMemAck = 1'b1;
        next_cycle();
        iMemAck = 1'b0;
        #1;
        check("wait_stall", oStall, 1);
        check("wait_memreq", oMemReq, 0);
        iRSTn = 1'b0;
        #1;
        check("midrst_stall", oStall, 0);
        check("midrst_memreq", oMemReq, 0);
        check("midrst_misscount", oMissCount, 0);
        check("midrst_memaddr", oMemAddr, 0);
        model_misses = 0;
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        iRSTn = 1'b1;
        next_cycle();
        fills = 0; resps = 0; stalls = 0;
        for (int c = 0; c < 6; c++) begin
            iMemValid = (c < 2);
            iMemData = $urandom;
            #1;
            fills += int'(oFillEn);
            resps += int'(oDataValid);
            stalls += int'(oStall);
            next_cycle();
        end
        idle_inputs();
        check("postrst_fills", fills, 0);
        check("postrst_resps", resps, 0);
        check("postrst_stalls", stalls, 0);
        do_miss(32'h0F0F_0F0C, 1, 0, 32'h7777_1111, -1);

`ifdef REFILL_TIMEOUT_EN
        iReq = 1'b1;
        iHit = 1'b0;
        iAddr = $urandom;
        err_n = 0; err_cyc = -1; resp_cyc = -1; fills = 0; resps = 0;
        rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 14; c++) begin
            if (c == 1) iReq = 1'b0;
            #1;
            if (oError) begin
                err_n++;
                err_cyc = c;
            end
            if (oDataValid) begin
                resps++;
                resp_cyc = c;
                rdata = oData;
            end
            fills += int'(oFillEn);
            next_cycle();
        end
        model_misses++;
        check("to_err_count", err_n, 1);
        check("to_err_cycle", err_cyc, 1 + TO);
        check("to_resp_count", resps, 1);
        check("to_resp_cycle", resp_cyc, 1 + TO);
        check("to_resp_data", rdata, 0);
        check("to_fills", fills, 0);
        check("to_miss_count", oMissCount, model_misses);
`endif

        for (int i = 0; i < 30; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 3) begin
                do_hit($urandom, $urandom, 1'b0);
            end else if (kind == 3) begin
                do_flush_req();
            end else begin
                a = int'($urandom_range(0, 3));
                d = int'($urandom_range(0, 3));
                fl = -1;
                if ($urandom_range(0, 2) == 0) fl = int'($urandom_range(1, 2 + a + d));
                do_miss($urandom, a, d, $urandom, fl);
            end
            repeat ($urandom_range(0, 2)) next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
